// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states and Booth-pair operations.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} booth_op_t;

  // {Q[0],Qm}: 01 adds M, 10 subtracts M, 00/11 leave A alone
  function automatic booth_op_t booth_op(input logic q0, input logic qm);
    case ({q0, qm})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on N-bit A/Q/M: add/sub selected by {Q[0],Qm}, then arithmetic shift right.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module booth_step
  import booth_pkg::*;
#(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  input  logic         qm,
  output logic [N-1:0] a_nxt,
  output logic [N-1:0] q_nxt,
  output logic         qm_nxt
);

  logic [N-1:0] sum;

  always_comb begin
    sum = a;
    case (booth_op(q[0], qm))
      OP_ADD:  sum = a + m;
      OP_SUB:  sum = a - m;
      default: sum = a;
    endcase
  end

  assign a_nxt  = {sum[N-1], sum[N-1:1]};
  assign q_nxt  = {sum[0], q[N-1:1]};
  assign qm_nxt = q[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned per operation; BOOTH_OVF_EN adds b_ovf.
// Latency: start sampled at edge 0, b_done high in the cycle after edge WIDTH+2.
// Backpressure: b_start is ignored while b_busy is high; nothing is queued.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               b_clk,
  input  logic               b_rst_n,
  input  logic               b_start,
  input  logic               b_signed,
  input  logic [WIDTH-1:0]   b_inp1,
  input  logic [WIDTH-1:0]   b_inp2,
  output logic               b_busy,
  output logic               b_done,
  output logic [2*WIDTH-1:0] b_out
`ifdef BOOTH_OVF_EN
  ,
  output logic               b_ovf
`endif
);

  localparam int N = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH + 1);

  state_t           state;
  logic [N-1:0]     a, q, m;
  logic             qm;
  logic [CNT_W-1:0] count;

  logic [N-1:0]       a_nxt, q_nxt;
  logic               qm_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [N-1:0]       ext1, ext2;

  // One extra bit lets the same Booth recoding serve unsigned operands
  assign ext1 = {b_signed & b_inp1[WIDTH-1], b_inp1};
  assign ext2 = {b_signed & b_inp2[WIDTH-1], b_inp2};
  assign prod = {a[WIDTH-2:0], q};

  booth_step #(.N(N)) u_step (
    .a      (a),
    .q      (q),
    .m      (m),
    .qm     (qm),
    .a_nxt  (a_nxt),
    .q_nxt  (q_nxt),
    .qm_nxt (qm_nxt)
  );

`ifdef BOOTH_OVF_EN
  logic mode_signed;
  logic ovf_calc;

  always_comb begin
    ovf_calc = |prod[2*WIDTH-1:WIDTH];
    if (mode_signed)
      ovf_calc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
  end

  always_ff @(posedge b_clk or negedge b_rst_n) begin
    if (!b_rst_n) begin
      mode_signed <= 1'b0;
      b_ovf       <= 1'b0;
    end else begin
      if (state == IDLE && b_start)
        mode_signed <= b_signed;
      if (state == RUN && count == '0)
        b_ovf <= ovf_calc;
    end
  end
`endif

  always_ff @(posedge b_clk or negedge b_rst_n) begin
    if (!b_rst_n) begin
      state  <= IDLE;
      a      <= '0;
      q      <= '0;
      m      <= '0;
      qm     <= 1'b0;
      count  <= '0;
      b_out  <= '0;
      b_busy <= 1'b0;
      b_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          b_done <= 1'b0;
          if (b_start) begin
            m      <= ext1;
            q      <= ext2;
            a      <= '0;
            qm     <= 1'b0;
            count  <= CNT_INIT;
            state  <= RUN;
            b_busy <= 1'b1;
          end
        end
        RUN: begin
          // Counter exhausted: all WIDTH+1 iterations are in {A,Q}
          if (count == '0) begin
            b_out  <= prod;
            b_done <= 1'b1;
            state  <= DONE;
          end else begin
            a     <= a_nxt;
            q     <= q_nxt;
            qm    <= qm_nxt;
            count <= count - 1'b1;
          end
        end
        DONE: begin
          b_done <= 1'b0;
          b_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          b_done <= 1'b0;
          b_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq (WIDTH=16): random and corner operands checked against integer products.
module tb_booth_mul_seq;

  localparam int W = 16;

  logic           b_clk = 1'b0;
  logic           b_rst_n = 1'b0;
  logic           b_start = 1'b0;
  logic           b_signed = 1'b0;
  logic [W-1:0]   b_inp1 = '0;
  logic [W-1:0]   b_inp2 = '0;
  logic           b_busy;
  logic           b_done;
  logic [2*W-1:0] b_out;
`ifdef BOOTH_OVF_EN
  logic           b_ovf;
`endif

  booth_mul_seq #(.WIDTH(W)) dut (
    .b_clk    (b_clk),
    .b_rst_n  (b_rst_n),
    .b_start  (b_start),
    .b_signed (b_signed),
    .b_inp1   (b_inp1),
    .b_inp2   (b_inp2),
    .b_busy   (b_busy),
    .b_done   (b_done),
    .b_out    (b_out)
`ifdef BOOTH_OVF_EN
    ,
    .b_ovf    (b_ovf)
`endif
  );

  always #5 b_clk = ~b_clk;

  typedef struct {
    logic [2*W-1:0] out;
    logic           ovf;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   issued = 0;
  bit   prev_done = 0;

  always @(posedge b_clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer product of the operands as interpreted in the selected mode
  function automatic exp_t model(input bit sg, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sa, sb_, p;
    sa = sg ? longint'($signed(x)) : longint'(x);
    sb_ = sg ? longint'($signed(y)) : longint'(y);
    p = sa * sb_;
    e.out = p[2*W-1:0];
    e.ovf = sg ? (p < -32768 || p > 32767) : (p > 65535);
    e.cyc = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input bit sg, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   guard;
    guard = 0;
    while (b_busy && guard < 100) begin
      @(negedge b_clk);
      guard++;
    end
    if (guard >= 100) chk("issue_wait_timeout", 1, 0);
    e = model(sg, x, y);
    e.cyc = cyc + 1;
    sb.push_back(e);
    issued++;
    b_signed = sg;
    b_inp1 = x;
    b_inp2 = y;
    b_start = 1'b1;
    @(negedge b_clk);
    b_start = 1'b0;
  endtask

  always @(negedge b_clk) begin
    exp_t e;
    if (prev_done) chk("busy_after_done", b_busy, 0);
    prev_done = (b_done === 1'b1);
    if (b_done === 1'b1) begin
      done_cnt++;
      chk("busy_during_done", b_busy, 1);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("product", b_out, e.out);
        chk("latency", cyc - e.cyc, W + 2);
`ifdef BOOTH_OVF_EN
        chk("ovf", b_ovf, e.ovf);
`endif
      end
    end
  end

  typedef struct {
    bit           sg;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } op_t;

  op_t dir[$];

  initial begin
    dir = '{
      '{1'b1, 16'd10, 16'd20},
      '{1'b1, 16'hFFF9, 16'd3},
      '{1'b1, 16'h8000, 16'h8000},
      '{1'b0, 16'hFFFF, 16'hFFFF},
      '{1'b1, 16'hFFFF, 16'hFFFF},
      '{1'b1, 16'd300, 16'd300},
      '{1'b1, 16'd100, 16'hFF9C},
      '{1'b0, 16'd256, 16'd256},
      '{1'b0, 16'd255, 16'd257},
      '{1'b1, 16'h7FFF, 16'h8000},
      '{1'b0, 16'd0, 16'hABCD}
    };

    repeat (2) @(negedge b_clk);
    chk("reset_busy", b_busy, 0);
    chk("reset_done", b_done, 0);
    chk("reset_out", b_out, 0);
    b_rst_n = 1'b1;
    @(negedge b_clk);

    foreach (dir[i]) issue(dir[i].sg, dir[i].x, dir[i].y);

    // A start pulse mid-run with different operands must be dropped
    issue(1'b1, 16'd1234, 16'd77);
    repeat (4) @(negedge b_clk);
    b_signed = 1'b0;
    b_inp1 = 16'hFFFF;
    b_inp2 = 16'h1111;
    b_start = 1'b1;
    @(negedge b_clk);
    b_start = 1'b0;

    for (int i = 0; i < 30; i++)
      issue(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));

    // Abort mid-run: expectation withdrawn, outputs back to reset values
    issue(1'b1, 16'd999, 16'd321);
    repeat (6) @(negedge b_clk);
    b_rst_n = 1'b0;
    sb.delete();
    issued--;
    #1;
    chk("abort_busy", b_busy, 0);
    chk("abort_done", b_done, 0);
    chk("abort_out", b_out, 0);
    @(negedge b_clk);
    b_rst_n = 1'b1;
    @(negedge b_clk);

    issue(1'b1, 16'hFF00, 16'd513);
    issue(1'b0, 16'd40000, 16'd3);

    for (int g = 0; g < 200 && sb.size() != 0; g++) @(negedge b_clk);
    chk("drain_empty", sb.size(), 0);
    repeat (3) @(negedge b_clk);
    chk("done_count", done_cnt, issued);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
